// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared types and helpers for the piso_stream_ser serializer slice.
//   piso_state_t : control FSM encoding (IDLE / SHIFT)
//   cnt_w()      : bit-counter width for a given word width
// ---------------------------------------------------------------------------
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

   // Counter width needed to count 0..width-1.
   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/piso_shift_core.sv
// ---------------------------------------------------------------------------
// piso_shift_core
// Shift register, bit counter, bit-order select and frame markers of the
// serializer.  Control (load / advance) comes from the top-level FSM.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_load           : load i_load_data into the shifter, counter to 0
//   i_load_data      : parallel word to serialize
//   i_active         : FSM is in SHIFT (current bit is a frame bit)
//   i_ser_en         : line consumes the current bit at this edge
//   o_bit            : bit at the output end of the shifter
//   o_last           : counter is at WIDTH-1
//   o_frame_start    : active and counter == 0
//   o_frame_end      : active and counter == WIDTH-1
// ---------------------------------------------------------------------------
module piso_shift_core
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_data,
   input  logic             i_active,
   input  logic             i_ser_en,
   output logic             o_bit,
   output logic             o_last,
   output logic             o_frame_start,
   output logic             o_frame_end
);

   localparam int            CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_cnt;
   logic             w_advance;

   assign w_advance = i_active & i_ser_en;

   // Shifter and bit counter: load has priority over advancing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_shreg <= i_load_data;
         r_cnt   <= '0;
      end else if (w_advance) begin
         // Shift toward the output end so the next bit lands there.
         if (LSB_FIRST) begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
         end else begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
         end
         // Clear after the last bit so the counter never leaves 0..WIDTH-1.
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
      end
   end

   assign o_bit         = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
   assign o_last        = (r_cnt == CNT_LAST);
   assign o_frame_start = i_active & (r_cnt == '0);
   assign o_frame_end   = i_active & o_last;

endmodule

// File: rtl/piso_stream_ser.sv
// ---------------------------------------------------------------------------
// piso_stream_ser
// Parallel-in / serial-out serializer with a valid/ready word input and a
// one-word holding buffer.  Back-to-back words leave as gapless frames.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : in_data holds a word to accept
//   in_data      : parallel word (sampled only on accept)
//   in_ready     : holding buffer is empty (registered, no input path)
//   ser_en       : line consumes the current bit at this edge
//   ser_out      : serial bit, IDLE_LEVEL when ser_valid is 0
//   ser_valid    : ser_out carries a frame bit
//   frame_start  : current bit is bit 0 of a frame
//   frame_end    : current bit is bit WIDTH-1 of a frame
//   busy         : shifting, or a word is held
// ---------------------------------------------------------------------------
module piso_stream_ser
   import piso_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter bit   LSB_FIRST  = 1'b0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             ser_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   piso_state_t      r_state;
   piso_state_t      w_state_nxt;
   logic [WIDTH-1:0] r_hold_data;
   logic             r_hold_full;
   logic             w_accept;
   logic             w_load;
   logic             w_active;
   logic             w_last;
   logic             w_bit;
   logic             w_frame_start;
   logic             w_frame_end;

   // An accept can only happen with an empty buffer, a load only with a
   // full one, so the two never coincide.
   assign w_accept = in_valid & ~r_hold_full;
   assign w_active = (r_state == SHIFT);

   // Load decode: start from IDLE, or reload at the frame boundary.
   always_comb begin
      w_load = 1'b0;
      case (r_state)
         IDLE:    w_load = r_hold_full;
         SHIFT:   w_load = r_hold_full & ser_en & w_last;
         default: w_load = 1'b0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (r_hold_full) begin
               w_state_nxt = SHIFT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (ser_en && w_last && !r_hold_full) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = SHIFT;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Holding buffer: filled on accept, emptied when the shifter loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_data <= '0;
         r_hold_full <= 1'b0;
      end else if (w_accept) begin
         r_hold_data <= in_data;
         r_hold_full <= 1'b1;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
      end
   end

   piso_shift_core #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_core (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_load        (w_load),
      .i_load_data   (r_hold_data),
      .i_active      (w_active),
      .i_ser_en      (ser_en),
      .o_bit         (w_bit),
      .o_last        (w_last),
      .o_frame_start (w_frame_start),
      .o_frame_end   (w_frame_end)
   );

   // FSM outputs, all decoded from registers.
   always_comb begin
      ser_valid   = 1'b0;
      ser_out     = IDLE_LEVEL;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      if (r_state == SHIFT) begin
         ser_valid   = 1'b1;
         ser_out     = w_bit;
         frame_start = w_frame_start;
         frame_end   = w_frame_end;
      end else begin
         ser_valid   = 1'b0;
         ser_out     = IDLE_LEVEL;
         frame_start = 1'b0;
         frame_end   = 1'b0;
      end
      in_ready = ~r_hold_full;
      busy     = (r_state == SHIFT) | r_hold_full;
   end

endmodule

// File: tb/tb_piso_stream_ser.sv
module tb_piso_stream_ser;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   // 8-bit MSB-first, idle low
   logic       v8m, en8m, ir8m, so8m, sv8m, fs8m, fe8m, bz8m;
   logic [7:0] d8m;
   // 8-bit LSB-first, idle high
   logic       v8l, en8l, ir8l, so8l, sv8l, fs8l, fe8l, bz8l;
   logic [7:0] d8l;
   // 4-bit LSB-first, idle low
   logic       v4l, en4l, ir4l, so4l, sv4l, fs4l, fe4l, bz4l;
   logic [3:0] d4l;

   // Expected bit streams, written in transmit order (leftmost bit first).
   logic [7:0]  e1;
   logic [7:0]  e2;
   logic [15:0] e3;
   logic [18:0] e4;
   logic [7:0]  e5;
   logic [7:0]  e6;

   piso_stream_ser #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u8m (
      .clk(clk), .rst_n(rst_n), .in_valid(v8m), .in_data(d8m), .in_ready(ir8m),
      .ser_en(en8m), .ser_out(so8m), .ser_valid(sv8m), .frame_start(fs8m),
      .frame_end(fe8m), .busy(bz8m));

   piso_stream_ser #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u8l (
      .clk(clk), .rst_n(rst_n), .in_valid(v8l), .in_data(d8l), .in_ready(ir8l),
      .ser_en(en8l), .ser_out(so8l), .ser_valid(sv8l), .frame_start(fs8l),
      .frame_end(fe8l), .busy(bz8l));

   piso_stream_ser #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u4l (
      .clk(clk), .rst_n(rst_n), .in_valid(v4l), .in_data(d4l), .in_ready(ir4l),
      .ser_en(en4l), .ser_out(so4l), .ser_valid(sv4l), .frame_start(fs4l),
      .frame_end(fe4l), .busy(bz4l));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; total = 0; bad = 0;
      v8m = 1'b0; d8m = 8'h00; en8m = 1'b1;
      v8l = 1'b0; d8l = 8'h00; en8l = 1'b1;
      v4l = 1'b0; d4l = 4'h0; en4l = 1'b1;
      e1 = 8'b0000_1111;
      e2 = 8'b1111_0000;
      e3 = 16'b0000_1111_1111_0000;
      e4 = 19'b10111100101_00111100;
      e5 = 8'b0011_1100;
      e6 = 8'b0001_0001;

      // Reset state
      #2;
      chk("rst ir", ir8m, 1); chk("rst so", so8m, 0); chk("rst sv", sv8m, 0);
      chk("rst fs", fs8m, 0); chk("rst fe", fe8m, 0); chk("rst busy", bz8m, 0);
      chk("rst so idle1", so8l, 1); chk("rst ir 4", ir4l, 1);
      #5 rst_n = 1'b1;

      // 1: MSB-first 0x0F
      v8m = 1'b1; d8m = 8'h0F;
      tick();
      v8m = 1'b0;
      chk("t1 ir after accept", ir8m, 0); chk("t1 busy held", bz8m, 1); chk("t1 sv latency", sv8m, 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t1 sv%0d", i), sv8m, 1);
         chk($sformatf("t1 bit%0d", i), so8m, e1[7-i]);
         chk($sformatf("t1 fs%0d", i), fs8m, (i == 0) ? 1 : 0);
         chk($sformatf("t1 fe%0d", i), fe8m, (i == 7) ? 1 : 0);
         tick();
      end
      chk("t1 end sv", sv8m, 0); chk("t1 end so", so8m, 0); chk("t1 end busy", bz8m, 0);

      // 2: LSB-first 0x0F, idle level 1
      v8l = 1'b1; d8l = 8'h0F;
      tick();
      v8l = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t2 bit%0d", i), so8l, e2[7-i]);
         chk($sformatf("t2 sv%0d", i), sv8l, 1);
         tick();
      end
      chk("t2 end sv", sv8l, 0); chk("t2 end so idle1", so8l, 1); chk("t2 end busy", bz8l, 0);

      // 3: back-to-back 0x0F, 0xF0 with in_valid held
      v8m = 1'b1; d8m = 8'h0F;
      tick();
      chk("t3 ir held", ir8m, 0);
      d8m = 8'hF0;
      tick();
      for (int j = 0; j < 16; j++) begin
         chk($sformatf("t3 sv%0d", j), sv8m, 1);
         chk($sformatf("t3 bit%0d", j), so8m, e3[15-j]);
         chk($sformatf("t3 fs%0d", j), fs8m, (j == 0 || j == 8) ? 1 : 0);
         chk($sformatf("t3 fe%0d", j), fe8m, (j == 7 || j == 15) ? 1 : 0);
         chk($sformatf("t3 ir%0d", j), ir8m, (j == 0 || j >= 8) ? 1 : 0);
         tick();
         if (j == 0) v8m = 1'b0;
      end
      chk("t3 end sv", sv8m, 0); chk("t3 end busy", bz8m, 0);

      // 4: backpressure on bit 3 of 0xA5, 0x3C pending
      v8m = 1'b1; d8m = 8'hA5;
      tick();
      d8m = 8'h3C;
      tick();
      for (int c = 0; c < 19; c++) begin
         chk($sformatf("t4 sv%0d", c), sv8m, 1);
         chk($sformatf("t4 bit%0d", c), so8m, e4[18-c]);
         chk($sformatf("t4 fs%0d", c), fs8m, (c == 0 || c == 11) ? 1 : 0);
         chk($sformatf("t4 fe%0d", c), fe8m, (c == 10 || c == 18) ? 1 : 0);
         chk($sformatf("t4 ir%0d", c), ir8m, (c == 0 || c >= 11) ? 1 : 0);
         en8m = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
         tick();
         if (c == 0) v8m = 1'b0;
      end
      en8m = 1'b1;
      chk("t4 end sv", sv8m, 0); chk("t4 end busy", bz8m, 0);

      // 5: reset during bit 4 of 0xA5 with 0x77 held
      v8m = 1'b1; d8m = 8'hA5;
      tick();
      d8m = 8'h77;
      tick();
      tick();
      v8m = 1'b0;
      tick();
      tick();
      chk("t5 pre bit4", so8m, 0); chk("t5 pre ir", ir8m, 0); chk("t5 pre busy", bz8m, 1);
      rst_n = 1'b0;
      #1;
      chk("t5 rst sv", sv8m, 0); chk("t5 rst so", so8m, 0); chk("t5 rst ir", ir8m, 1);
      chk("t5 rst busy", bz8m, 0); chk("t5 rst fs", fs8m, 0); chk("t5 rst fe", fe8m, 0);
      #2 rst_n = 1'b1;
      tick();
      chk("t5 no resume sv", sv8m, 0); chk("t5 no resume busy", bz8m, 0);
      v8m = 1'b1; d8m = 8'h3C;
      tick();
      v8m = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t5 bit%0d", i), so8m, e5[7-i]);
         chk($sformatf("t5 fs%0d", i), fs8m, (i == 0) ? 1 : 0);
         chk($sformatf("t5 fe%0d", i), fe8m, (i == 7) ? 1 : 0);
         tick();
      end
      chk("t5 end sv", sv8m, 0);

      // 6: WIDTH=4 LSB-first, 4'b1000 twice back-to-back
      v4l = 1'b1; d4l = 4'b1000;
      tick();
      tick();
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("t6 sv%0d", j), sv4l, 1);
         chk($sformatf("t6 bit%0d", j), so4l, e6[7-j]);
         chk($sformatf("t6 fs%0d", j), fs4l, (j == 0 || j == 4) ? 1 : 0);
         chk($sformatf("t6 fe%0d", j), fe4l, (j == 3 || j == 7) ? 1 : 0);
         chk($sformatf("t6 ir%0d", j), ir4l, (j == 0 || j >= 4) ? 1 : 0);
         tick();
         if (j == 0) v4l = 1'b0;
      end
      chk("t6 end sv", sv4l, 0); chk("t6 end busy", bz4l, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
